hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage IF/ID/EX/MEM/WB core. Generates PC/IF-ID write enables,
//  per-stage flush (bubble) and hold controls, and EX-stage forwarding selects. Also runs the

---
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: hazard-detect inputs, pipeline controls,
// forwarding selects and performance counters.
interface hazard_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] id_rs_a;
   logic [REG_ADDR_W-1:0] id_rt_a;
   logic                  id_uses_rt;
   logic [REG_ADDR_W-1:0] ex_rs_a;
   logic [REG_ADDR_W-1:0] ex_rt_a;
   logic                  ex_read_mem;
   logic [REG_ADDR_W-1:0] mem_dst_a;
   logic                  mem_reg_write;
   logic [REG_ADDR_W-1:0] wb_dst_a;
   logic                  wb_reg_write;
   logic                  redirect;
   logic                  mem_req;
   logic                  mem_ready;

   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic                  exmem_flush;
   logic                  pipe_hold;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  mem_err;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   modport master (
      output id_rs_a, id_rt_a, id_uses_rt, ex_rs_a, ex_rt_a, ex_read_mem,
             mem_dst_a, mem_reg_write, wb_dst_a, wb_reg_write, redirect,
             mem_req, mem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
             pipe_hold, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs_a, id_rt_a, id_uses_rt, ex_rs_a, ex_rt_a, ex_read_mem,
             mem_dst_a, mem_reg_write, wb_dst_a, wb_reg_write, redirect,
             mem_req, mem_ready,
      output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
             pipe_hold, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush/hold generation, EX forwarding
// selects, data-memory wait FSM with timeout, and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hc
);

   localparam int unsigned WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN,
      S_WAIT,
      S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic freeze;
   logic load_use;
   logic redirect_taken;
   logic pc_write_c;
   logic ifid_write_c;
   logic ifid_flush_c;
   logic idex_flush_c;
   logic exmem_flush_c;
   logic pipe_hold_c;
   logic [1:0] fwd_a_c;
   logic [1:0] fwd_b_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RUN;
         wcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Wait FSM: wcnt counts frozen cycles already spent on the current access.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         S_RUN: begin
            if (hc.mem_req && !hc.mem_ready) begin
               state_d = S_WAIT;
               wcnt_d  = WCNT_W'(1);
            end
         end
         S_WAIT: begin
            if (hc.mem_ready) begin
               state_d = S_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_LAST) begin
               state_d = S_ERR;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      freeze   = (state_q == S_ERR) || (hc.mem_req && !hc.mem_ready);
      load_use = hc.ex_read_mem && (hc.ex_rt_a != '0) &&
                 ((hc.ex_rt_a == hc.id_rs_a) || (hc.id_uses_rt && (hc.ex_rt_a == hc.id_rt_a)));
   end

   // Priority: reset > freeze > redirect > load-use > free run.
   always_comb begin
      pc_write_c     = 1'b1;
      ifid_write_c   = 1'b1;
      ifid_flush_c   = 1'b0;
      idex_flush_c   = 1'b0;
      exmem_flush_c  = 1'b0;
      pipe_hold_c    = 1'b0;
      redirect_taken = 1'b0;
      if (rst) begin
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         ifid_flush_c  = 1'b1;
         idex_flush_c  = 1'b1;
         exmem_flush_c = 1'b1;
      end else if (freeze) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         pipe_hold_c  = 1'b1;
      end else if (hc.redirect) begin
         ifid_flush_c   = 1'b1;
         idex_flush_c   = 1'b1;
         exmem_flush_c  = 1'b1;
         redirect_taken = 1'b1;
      end else if (load_use) begin
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         idex_flush_c = 1'b1;
      end
   end

   // EX/MEM result is younger than MEM/WB, so it wins on a double match.
   always_comb begin
      fwd_a_c = 2'b00;
      fwd_b_c = 2'b00;
      if (!rst) begin
         if (hc.mem_reg_write && (hc.mem_dst_a != '0) && (hc.mem_dst_a == hc.ex_rs_a))
            fwd_a_c = 2'b10;
         else if (hc.wb_reg_write && (hc.wb_dst_a != '0) && (hc.wb_dst_a == hc.ex_rs_a))
            fwd_a_c = 2'b01;
         if (hc.mem_reg_write && (hc.mem_dst_a != '0) && (hc.mem_dst_a == hc.ex_rt_a))
            fwd_b_c = 2'b10;
         else if (hc.wb_reg_write && (hc.wb_dst_a != '0) && (hc.wb_dst_a == hc.ex_rt_a))
            fwd_b_c = 2'b01;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_c && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect_taken && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   assign hc.pc_write    = pc_write_c;
   assign hc.ifid_write  = ifid_write_c;
   assign hc.ifid_flush  = ifid_flush_c;
   assign hc.idex_flush  = idex_flush_c;
   assign hc.exmem_flush = exmem_flush_c;
   assign hc.pipe_hold   = pipe_hold_c;
   assign hc.fwd_a       = fwd_a_c;
   assign hc.fwd_b       = fwd_b_c;
   assign hc.mem_err     = (state_q == S_ERR);
   assign hc.stall_cnt   = stall_cnt_q;
   assign hc.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a cycle-count reference model.
module tb_hazard_ctrl;

   localparam int unsigned AW   = 5;
   localparam int unsigned MT   = 6;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hif ();

   hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hc  (hif.slave)
   );

   always #5 clk = ~clk;

   // ctrl vector order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold}
   typedef struct {
      logic [AW-1:0] id_rs, id_rt;
      logic          uses_rt;
      logic [AW-1:0] ex_rs, ex_rt;
      logic          rd_mem;
      logic [AW-1:0] mdst;
      logic          mwr;
      logic [AW-1:0] wdst;
      logic          wwr;
      logic          redir;
      logic [5:0]    ectrl;
      logic [1:0]    efa, efb;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input int id_rs, id_rt, uses_rt, ex_rs, ex_rt, rd_mem,
                               mdst, mwr, wdst, wwr, redir,
                               input logic [5:0] ectrl, input logic [1:0] efa, efb);
      vec_t v;
      v.id_rs = AW'(id_rs); v.id_rt = AW'(id_rt); v.uses_rt = uses_rt[0];
      v.ex_rs = AW'(ex_rs); v.ex_rt = AW'(ex_rt); v.rd_mem = rd_mem[0];
      v.mdst = AW'(mdst); v.mwr = mwr[0]; v.wdst = AW'(wdst); v.wwr = wwr[0];
      v.redir = redir[0]; v.ectrl = ectrl; v.efa = efa; v.efb = efb;
      return v;
   endfunction

   function automatic logic [5:0] ctrl();
      return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush,
              hif.exmem_flush, hif.pipe_hold};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      hif.id_rs_a = '0; hif.id_rt_a = '0; hif.id_uses_rt = 1'b0;
      hif.ex_rs_a = '0; hif.ex_rt_a = '0; hif.ex_read_mem = 1'b0;
      hif.mem_dst_a = '0; hif.mem_reg_write = 1'b0;
      hif.wb_dst_a = '0; hif.wb_reg_write = 1'b0;
      hif.redirect = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cyc();
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
   endtask

   function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
      if (hif.mem_reg_write && hif.mem_dst_a != 0 && hif.mem_dst_a == src) return 2'b10;
      if (hif.wb_reg_write && hif.wb_dst_a != 0 && hif.wb_dst_a == src) return 2'b01;
      return 2'b00;
   endfunction

   int  m_wait, m_stall, m_flush;
   bit  m_err;

   initial begin
      // Reset with every input trying to provoke activity.
      rst = 1'b1;
      idle();
      hif.redirect = 1'b1; hif.mem_req = 1'b1;
      hif.ex_rs_a = 5'd5; hif.mem_dst_a = 5'd5; hif.mem_reg_write = 1'b1;
      #3;
      chk("reset_ctrl", 32'(ctrl()), 32'h0E);
      chk("reset_fwd_a", 32'(hif.fwd_a), 0);
      chk("reset_stall", 32'(hif.stall_cnt), 0);
      chk("reset_flush", 32'(hif.flush_cnt), 0);
      chk("reset_err", 32'(hif.mem_err), 0);
      cyc();
      rst = 1'b0;
      idle();

      // id_rs id_rt uses ex_rs ex_rt rd mdst mwr wdst wwr redir ctrl fa fb
      vq.push_back(mk(1, 2, 1, 3, 4, 0, 0, 0, 0, 0, 0, 6'b110000, 2'b00, 2'b00));
      vq.push_back(mk(1, 2, 1, 3, 1, 1, 0, 0, 0, 0, 0, 6'b000100, 2'b00, 2'b00));
      vq.push_back(mk(2, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 6'b000100, 2'b00, 2'b00));
      vq.push_back(mk(2, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 6'b110000, 2'b00, 2'b00));
      vq.push_back(mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 6'b110000, 2'b00, 2'b00));
      vq.push_back(mk(3, 2, 1, 3, 3, 1, 0, 0, 0, 0, 1, 6'b111110, 2'b00, 2'b00));
      vq.push_back(mk(1, 2, 1, 5, 6, 0, 5, 1, 6, 1, 0, 6'b110000, 2'b10, 2'b01));
      vq.push_back(mk(1, 2, 1, 5, 5, 0, 5, 1, 5, 1, 0, 6'b110000, 2'b10, 2'b10));
      vq.push_back(mk(1, 2, 1, 5, 5, 0, 5, 0, 5, 1, 0, 6'b110000, 2'b01, 2'b01));
      vq.push_back(mk(1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0, 6'b110000, 2'b00, 2'b00));
      vq.push_back(mk(1, 2, 1, 7, 7, 0, 0, 0, 7, 0, 0, 6'b110000, 2'b00, 2'b00));

      foreach (vq[i]) begin
         cyc();
         hif.id_rs_a = vq[i].id_rs; hif.id_rt_a = vq[i].id_rt; hif.id_uses_rt = vq[i].uses_rt;
         hif.ex_rs_a = vq[i].ex_rs; hif.ex_rt_a = vq[i].ex_rt; hif.ex_read_mem = vq[i].rd_mem;
         hif.mem_dst_a = vq[i].mdst; hif.mem_reg_write = vq[i].mwr;
         hif.wb_dst_a = vq[i].wdst; hif.wb_reg_write = vq[i].wwr;
         hif.redirect = vq[i].redir; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
         #2;
         chk($sformatf("vec%0d_ctrl", i), 32'(ctrl()), 32'(vq[i].ectrl));
         chk($sformatf("vec%0d_fwd_a", i), 32'(hif.fwd_a), 32'(vq[i].efa));
         chk($sformatf("vec%0d_fwd_b", i), 32'(hif.fwd_b), 32'(vq[i].efb));
      end

      do_reset();

      // T1: load-use gives exactly one bubble.
      cyc();
      hif.ex_read_mem = 1'b1; hif.ex_rt_a = 5'd2; hif.id_rs_a = 5'd2;
      hif.id_rt_a = 5'd4; hif.id_uses_rt = 1'b1;
      #2;
      chk("t1_bubble", 32'(ctrl()), 32'h04);
      cyc();
      hif.ex_read_mem = 1'b0; hif.ex_rs_a = 5'd2; hif.ex_rt_a = 5'd4;
      hif.mem_dst_a = 5'd2; hif.mem_reg_write = 1'b1; hif.id_rs_a = 5'd7; hif.id_rt_a = 5'd8;
      #2;
      chk("t1_release", 32'(ctrl()), 32'h30);
      chk("t1_stall_cnt", 32'(hif.stall_cnt), 1);
      chk("t1_fwd_a", 32'(hif.fwd_a), 2);

      // T2: forwarding priority and register 0.
      cyc();
      hif.mem_dst_a = 5'd5; hif.wb_dst_a = 5'd5; hif.ex_rs_a = 5'd5;
      hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
      #2;
      chk("t2_both", 32'(hif.fwd_a), 2);
      hif.mem_dst_a = 5'd0;
      #1;
      chk("t2_wb_only", 32'(hif.fwd_a), 1);
      hif.ex_rs_a = 5'd0; hif.wb_dst_a = 5'd0;
      #1;
      chk("t2_reg0", 32'(hif.fwd_a), 0);

      // T3: redirect outranks load-use.
      cyc();
      idle();
      hif.redirect = 1'b1; hif.ex_read_mem = 1'b1; hif.ex_rt_a = 5'd3; hif.id_rs_a = 5'd3;
      #2;
      chk("t3_ctrl", 32'(ctrl()), 32'h3E);
      cyc();
      idle();
      #2;
      chk("t3_flush_cnt", 32'(hif.flush_cnt), 1);
      chk("t3_stall_cnt", 32'(hif.stall_cnt), 1);

      // T4: three wait cycles then ready.
      for (int k = 0; k < 3; k++) begin
         cyc();
         hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
         #2;
         chk($sformatf("t4_hold%0d", k), 32'(ctrl()), 32'h01);
      end
      cyc();
      hif.mem_ready = 1'b1;
      #2;
      chk("t4_ready", 32'(ctrl()), 32'h30);
      cyc();
      idle();
      #2;
      chk("t4_stall_cnt", 32'(hif.stall_cnt), 4);
      chk("t4_err", 32'(hif.mem_err), 0);

      // T5: timeout to ERR; freeze sticks; stall counter saturates.
      for (int k = 0; k < int'(MT); k++) begin
         cyc();
         hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
         #2;
         chk($sformatf("t5_hold%0d", k), 32'(ctrl()), 32'h01);
         chk($sformatf("t5_noerr%0d", k), 32'(hif.mem_err), 0);
      end
      cyc();
      hif.mem_ready = 1'b1; hif.redirect = 1'b1;
      #2;
      chk("t5_err", 32'(hif.mem_err), 1);
      chk("t5_frozen", 32'(ctrl()), 32'h01);
      chk("t5_stall_cnt", 32'(hif.stall_cnt), 10);
      for (int k = 0; k < 8; k++) cyc();
      #2;
      chk("t5_stall_sat", 32'(hif.stall_cnt), CMAX);
      chk("t5_flush_cnt", 32'(hif.flush_cnt), 1);

      // T6: reset clears ERR and a mid-WAIT reset restarts the timeout window.
      cyc();
      rst = 1'b1;
      #1;
      chk("t6_err_clr", 32'(hif.mem_err), 0);
      chk("t6_stall_clr", 32'(hif.stall_cnt), 0);
      chk("t6_flush_clr", 32'(hif.flush_cnt), 0);
      chk("t6_rst_ctrl", 32'(ctrl()), 32'h0E);
      cyc();
      rst = 1'b0; hif.redirect = 1'b0; hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
      cyc();
      cyc();
      cyc();
      rst = 1'b1; hif.redirect = 1'b1;
      #1;
      chk("t6_midwait_ctrl", 32'(ctrl()), 32'h0E);
      chk("t6_midwait_stall", 32'(hif.stall_cnt), 0);
      cyc();
      rst = 1'b0; hif.redirect = 1'b0; hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
      for (int k = 0; k < int'(MT); k++) begin
         #2;
         chk($sformatf("t6_window%0d", k), 32'(hif.mem_err), 0);
         cyc();
      end
      #2;
      chk("t6_timeout", 32'(hif.mem_err), 1);

      // Randomized run against the reference model.
      do_reset();
      m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
      for (int n = 0; n < 600; n++) begin
         logic       frz, lu;
         logic [5:0] e;
         cyc();
         hif.id_rs_a = AW'($urandom_range(0, 3)); hif.id_rt_a = AW'($urandom_range(0, 3));
         hif.id_uses_rt = 1'($urandom_range(0, 1));
         hif.ex_rs_a = AW'($urandom_range(0, 3)); hif.ex_rt_a = AW'($urandom_range(0, 3));
         hif.ex_read_mem = ($urandom_range(0, 99) < 40);
         hif.mem_dst_a = AW'($urandom_range(0, 3)); hif.mem_reg_write = 1'($urandom_range(0, 1));
         hif.wb_dst_a = AW'($urandom_range(0, 3)); hif.wb_reg_write = 1'($urandom_range(0, 1));
         hif.redirect = ($urandom_range(0, 99) < 15);
         hif.mem_req = ($urandom_range(0, 99) < 30);
         hif.mem_ready = ($urandom_range(0, 99) < 60);
         rst = ($urandom_range(0, 99) < 2);
         if (rst) begin
            m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
         end else if (m_wait > 0 && !m_err) begin
            hif.mem_req = 1'b1;
         end
         #2;
         frz = m_err || (hif.mem_req && !hif.mem_ready);
         lu = hif.ex_read_mem && hif.ex_rt_a != 0 &&
              (hif.ex_rt_a == hif.id_rs_a || (hif.id_uses_rt && hif.ex_rt_a == hif.id_rt_a));
         if (rst)               e = 6'b001110;
         else if (frz)          e = 6'b000001;
         else if (hif.redirect) e = 6'b111110;
         else if (lu)           e = 6'b000100;
         else                   e = 6'b110000;
         chk("rnd_ctrl", 32'(ctrl()), 32'(e));
         chk("rnd_fwd_a", 32'(hif.fwd_a), rst ? 0 : 32'(ref_fwd(hif.ex_rs_a)));
         chk("rnd_fwd_b", 32'(hif.fwd_b), rst ? 0 : 32'(ref_fwd(hif.ex_rt_a)));
         chk("rnd_stall_cnt", 32'(hif.stall_cnt), m_stall);
         chk("rnd_flush_cnt", 32'(hif.flush_cnt), m_flush);
         chk("rnd_mem_err", 32'(hif.mem_err), 32'(m_err));
         if (!rst) begin
            if (!e[5] && m_stall < CMAX) m_stall++;
            if (!frz && hif.redirect && m_flush < CMAX) m_flush++;
            if (!m_err) begin
               if (hif.mem_req && !hif.mem_ready) begin
                  m_wait++;
                  if (m_wait == int'(MT)) m_err = 1;
               end else begin
                  m_wait = 0;
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
